// File: rtl/uart_hex_logger_pkg.sv
// Shared constants, state encoding and ASCII helpers for the hex line logger.
// Optional banner support is compiled in with UART_HEX_LOGGER_BANNER_EN.
package uart_hex_logger_pkg;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_BANG = 8'h21;

`ifdef UART_HEX_LOGGER_BANNER_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PREFIX = 3'd1,
        ST_DIGIT  = 3'd2,
        ST_CR     = 3'd3,
        ST_LF     = 3'd4,
        ST_BANNER = 3'd5
    } state_t;

    // "HELLO!\r\n", sent once after reset
    function automatic logic [7:0] banner_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'h48;
            3'd1:    return 8'h45;
            3'd2:    return 8'h4C;
            3'd3:    return 8'h4C;
            3'd4:    return 8'h4F;
            3'd5:    return 8'h21;
            3'd6:    return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PREFIX = 3'd1,
        ST_DIGIT  = 3'd2,
        ST_CR     = 3'd3,
        ST_LF     = 3'd4
    } state_t;
`endif

    function automatic logic [7:0] hex_digit(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

endpackage

// File: rtl/hexlog_sync_fifo.sv
// Single-clock FIFO with occupancy output; the caller must never write when
// full or read when empty.
module hexlog_sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_hex_logger.sv
// Buffers event words and streams each as an uppercase hex line ending CR LF.
// Define UART_HEX_LOGGER_BANNER_EN to send "HELLO!\r\n" after every reset.
module uart_hex_logger
    import uart_hex_logger_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_strobe,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     tx_ready,
    output logic [7:0]               out_data,
    output logic                     out_strobe,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               drop_count,
    output logic                     busy
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int NIB_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int LVL_W   = $clog2(DEPTH) + 1;

    state_t           state;
    state_t           state_nx;
    logic [NIB_W-1:0] nib;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] fifo_head;
    logic             ovf_flag;
    logic             full;
    logic             wr_en;
    logic             drop;
    logic             pop;
    logic             can_emit;
    logic             emit;
    logic [7:0]       byte_nx;
`ifdef UART_HEX_LOGGER_BANNER_EN
    logic [2:0]       ban_idx;
`endif

    // Fullness is judged on the registered level, so a write racing a pop
    // on a full FIFO is still dropped.
    assign full  = (fifo_level == LVL_W'(DEPTH));
    assign wr_en = in_strobe && !full;
    assign drop  = in_strobe && full;
    assign busy  = (state != ST_IDLE) || (fifo_level != '0);

    hexlog_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .level   (fifo_level)
    );

    always_comb begin
        state_nx = state;
        byte_nx  = 8'h00;
        emit     = 1'b0;
        pop      = 1'b0;
        // Back-to-back strobes are never allowed: at least one idle cycle per byte
        can_emit = tx_ready && !out_strobe;
        case (state)
            ST_IDLE: begin
                if (fifo_level != '0 && tx_ready) begin
                    pop      = 1'b1;
                    state_nx = ovf_flag ? ST_PREFIX : ST_DIGIT;
                end
            end
            ST_PREFIX: begin
                byte_nx = ASCII_BANG;
                emit    = can_emit;
                if (can_emit) state_nx = ST_DIGIT;
            end
            ST_DIGIT: begin
                byte_nx = hex_digit(shift_reg[WIDTH-1 -: 4]);
                emit    = can_emit;
                if (can_emit && nib == '0) state_nx = ST_CR;
            end
            ST_CR: begin
                byte_nx = ASCII_CR;
                emit    = can_emit;
                if (can_emit) state_nx = ST_LF;
            end
            ST_LF: begin
                byte_nx = ASCII_LF;
                emit    = can_emit;
                if (can_emit) state_nx = ST_IDLE;
            end
`ifdef UART_HEX_LOGGER_BANNER_EN
            ST_BANNER: begin
                byte_nx = banner_byte(ban_idx);
                emit    = can_emit;
                if (can_emit && ban_idx == 3'd7) state_nx = ST_IDLE;
            end
`endif
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
`ifdef UART_HEX_LOGGER_BANNER_EN
            state   <= ST_BANNER;
            ban_idx <= 3'd0;
`else
            state   <= ST_IDLE;
`endif
            out_strobe <= 1'b0;
            out_data   <= 8'h00;
            drop_count <= 8'h00;
            ovf_flag   <= 1'b0;
            nib        <= '0;
        end else begin
            state      <= state_nx;
            out_strobe <= emit;
            if (emit) out_data <= byte_nx;
            // A drop on the same edge as the '!' wins, so it still marks a later line
            if (drop) begin
                ovf_flag <= 1'b1;
                if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            end else if (emit && state == ST_PREFIX) begin
                ovf_flag <= 1'b0;
            end
            if (pop) nib <= NIB_W'(NIBBLES - 1);
            else if (emit && state == ST_DIGIT) nib <= nib - 1'b1;
`ifdef UART_HEX_LOGGER_BANNER_EN
            if (emit && state == ST_BANNER) ban_idx <= ban_idx + 3'd1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (pop) shift_reg <= fifo_head;
        else if (emit && state == ST_DIGIT) shift_reg <= shift_reg << 4;
    end

endmodule
